circle_buf_rd_sequencer: RTL and testbench
==========================================

Name: circle_buf_rd_sequencer

Overview:
- Read-side controller for the double-buffered trigger capture memory.
- Waits for a filled bank and drives its read strobe and rewind inputs to drain the bank in address order.
- Hands words to a downstream consumer over a valid/ready interface with sof/eof framing and backpressure; a 2-entry output FIFO makes backpressure lossless.
- Supports a mid-frame restart (rewind replay) and counts completed frames.

Parameters:
aw, 13, address width of one bank; frame length = 2^aw words
dw, 16, data word width

Ports:
rclk  input  1  read-side clock; the only clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 permits starting new frames
oneshot  input  1  level; 1 = stop in IDLE after each frame until enable falls and rises
restart  input  1  pulse; replay current bank from address 0
r_bank_available  input  1  buffer has a readable bank
r_addr  input  aw  buffer's current read address
data_r  input  dw  buffer read data
data_gate_out  input  1  data_r valid, one cycle after an accepted stb_r
stb_r  output  1  read strobe to buffer
rewind  output  1  reset buffer read address to 0
out_data  output  dw  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts when high with out_valid
out_sof  output  1  head word is index 0 of frame
out_eof  output  1  head word is index 2^aw-1
busy  output  1  state != IDLE or FIFO non-empty
frame_count  output  16  frames fully issued since reset, wraps at 65535→0
addr_err  output  1  sticky: r_addr != issue index when stb_r high

Behaviour:
- Reset (async, reset_n=0): state IDLE; stb_r=0, rewind=0, out_valid=0, out_sof=0, out_eof=0, busy=0, frame_count=0, addr_err=0; FIFO emptied; issue index idx=0; inflight=0; armed=1.
- States:
  - IDLE: go to READ when enable & armed & r_bank_available; idx=0.
  - READ: issue words.
  - REWIND: one cycle; rewind=1, stb_r=0, idx←0; next state READ.
  - LAST: wait until inflight=0; then frame_count+1; if oneshot, armed←0, else stay armed; go to IDLE.
- armed: set again when enable=0 is seen in IDLE.
- Credit rule: pop = out_valid & out_ready. stb_r = (state==READ) & r_bank_available & (occ + inflight − pop < 2), where occ = FIFO count (0..2) and inflight = registered stb_r.
- On each stb_r: idx+1. The strobe at idx=2^aw−1 marks the in-flight word eof; the buffer swaps bank on that strobe; next state LAST.
- Push: when data_gate_out=1, write data_r with the sof/eof tags captured at issue into the FIFO tail. Push and pop in the same cycle are both performed. A push into a full FIFO cannot occur under the credit rule; the bench asserts this.
- Latency: stb_r → FIFO entry one cycle later. out_valid rises the cycle after the push (registered). Sustained throughput is 1 word/cycle with out_ready=1.
- restart:
  - Sampled only in READ, and only if the eof strobe has not yet issued.
  - Next cycle is REWIND. Words already in the FIFO or in flight are still delivered; the replayed frame begins with a new sof.
  - Ignored in IDLE, REWIND and LAST.
  - restart coincident with an eligible stb_r: the strobe is suppressed and restart wins.
- enable falling in READ: the current frame completes; no new frame starts.
- r_bank_available dropping mid-READ: stb_r holds low until it returns; idx is kept.
- addr_err: set when stb_r=1 and r_addr != idx; cleared only by reset.
- frame_count does not increment for an aborted (restarted) pass.

Test Plan:
- Bench configuration for all scenarios: aw=3, memory model with 1-cycle gate, bank word i = 0x100*bank+i.
- Basic frame: enable=1, out_ready=1, bank ready → 8 consecutive stb_r; out_data 0x000..0x007 on 8 consecutive cycles; sof on the first, eof on the last; frame_count=1; busy falls after the last pop.
- Backpressure: out_ready toggling 1,0,0,1 repeatedly → no lost or duplicated words, FIFO never overflows, order 0..7 preserved, stb_r never high while occ+inflight−pop ≥ 2.
- Restart: restart pulse after the 4th stb_r → rewind=1 for one cycle, no stb_r that cycle. Output is words 0..3 (sof on 0), then 0..7 with a new sof on the second word 0 and eof on 7; frame_count=1.
- Oneshot: oneshot=1, two banks ready → exactly one frame read and the FSM stays in IDLE. Deassert then reassert enable → the second frame 0x100..0x107 is read; frame_count=2.
- Async reset mid-frame: reset_n low after 5 words → all outputs 0 immediately; after release with bank ready, a new frame starts at idx 0 with sof.
- Address check: model r_addr stuck at 2 → addr_err=1 from the strobe at idx 3 onward, held until reset.

Source files
------------

// File: rtl/circle_buf_rd_sequencer.sv
// Read-side sequencer for the double-buffered capture memory: drains a filled bank in
// address order into a 2-entry output FIFO with sof/eof framing and credit-based backpressure.
module circle_buf_rd_sequencer #(
    parameter int aw = 13,
    parameter int dw = 16
) (
    input  logic          rclk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          oneshot,
    input  logic          restart,
    input  logic          r_bank_available,
    input  logic [aw-1:0] r_addr,
    input  logic [dw-1:0] data_r,
    input  logic          data_gate_out,
    output logic          stb_r,
    output logic          rewind,
    output logic [dw-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic          out_eof,
    output logic          busy,
    output logic [15:0]   frame_count,
    output logic          addr_err
);

    // state  | meaning
    // IDLE   | waiting for enable, armed and a readable bank
    // READ   | issuing strobes for the current frame
    // REWIND | one-cycle replay of the bank from address 0
    // LAST   | eof strobe issued, waiting for the final word to land
    typedef enum logic [1:0] {IDLE, READ, REWIND, LAST} state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   idx_q, idx_d;
    logic            armed_q, armed_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            inflight_q;
    logic            infl_sof_q, infl_eof_q;
    logic            addr_err_q;

    logic [dw+1:0]   fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      occ_q, occ_d;

    logic            pop, push, credit_ok, last_idx;

    assign last_idx  = (idx_q == {aw{1'b1}});
    assign pop       = (occ_q != 2'd0) & out_ready;
    assign push      = data_gate_out & ((occ_q != 2'd2) | pop);
    // Words already in flight count against FIFO space so backpressure never drops data.
    assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge rclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            armed_q       <= 1'b1;
            frame_count_q <= '0;
            inflight_q    <= 1'b0;
            infl_sof_q    <= 1'b0;
            infl_eof_q    <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            armed_q       <= armed_d;
            frame_count_q <= frame_count_d;
            inflight_q    <= stb_r;
            if (stb_r) begin
                infl_sof_q <= (idx_q == '0);
                infl_eof_q <= last_idx;
            end
            if (stb_r && (r_addr != idx_q)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        armed_d       = armed_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (!enable) begin
                    armed_d = 1'b1;
                end else if (armed_q && r_bank_available) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (restart) begin
                    state_d = REWIND;
                end else if (stb_r) begin
                    idx_d = idx_q + aw'(1);
                    if (last_idx) begin
                        state_d = LAST;
                    end
                end
            end
            REWIND: begin
                idx_d   = '0;
                state_d = READ;
            end
            LAST: begin
                if (!inflight_q) begin
                    frame_count_d = frame_count_q + 16'd1;
                    armed_d       = oneshot ? 1'b0 : armed_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stb_r  = 1'b0;
        rewind = 1'b0;
        case (state_q)
            READ:    stb_r  = r_bank_available & credit_ok & ~restart;
            REWIND:  rewind = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push && pop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge rclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {data_r, infl_sof_q, infl_eof_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign out_valid   = (occ_q != 2'd0);
    assign out_data    = fifo_q[rd_ptr_q][dw+1:2];
    assign out_sof     = out_valid & fifo_q[rd_ptr_q][1];
    assign out_eof     = out_valid & fifo_q[rd_ptr_q][0];
    assign busy        = (state_q != IDLE) | out_valid;
    assign frame_count = frame_count_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_circle_buf_rd_sequencer.sv
// Scoreboard bench for circle_buf_rd_sequencer: behavioural two-bank buffer model,
// expected frames queued from stimulus, monitor pops and compares on each handshake.
module tb_circle_buf_rd_sequencer;
    localparam int AW   = 3;
    localparam int DW   = 16;
    localparam int FLEN = 8;

    logic          rclk = 1'b0;
    logic          reset_n, enable, oneshot, restart;
    logic          r_bank_available;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] data_r;
    logic          data_gate_out;
    logic          stb_r, rewind;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sof, out_eof, busy;
    logic [15:0]   frame_count;
    logic          addr_err;

    circle_buf_rd_sequencer #(.aw(AW), .dw(DW)) dut (
        .rclk(rclk), .reset_n(reset_n), .enable(enable), .oneshot(oneshot),
        .restart(restart), .r_bank_available(r_bank_available), .r_addr(r_addr),
        .data_r(data_r), .data_gate_out(data_gate_out), .stb_r(stb_r), .rewind(rewind),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frame_count(frame_count),
        .addr_err(addr_err)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // ---------------- buffer model ----------------
    int            banks_added = 0;
    int            banks_used  = 0;
    logic [AW-1:0] ptr;
    logic          stuck = 1'b0;
    logic          hold  = 1'b0;

    assign r_bank_available = (banks_added > banks_used) && !hold;
    assign r_addr = (stuck && ptr > 3'd2) ? 3'd2 : ptr;

    always @(posedge rclk or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            data_gate_out <= 1'b0;
            data_r        <= '0;
        end else begin
            data_gate_out <= stb_r;
            if (stb_r) begin
                data_r <= 16'((banks_used % 2) * 256 + int'(ptr));
                if (ptr == 3'(FLEN - 1)) begin
                    ptr        <= '0;
                    banks_used <= banks_used + 1;
                end else begin
                    ptr <= ptr + 3'd1;
                end
            end else if (rewind) begin
                ptr <= '0;
            end
        end
    end

    // ---------------- consumer ready / bank hold driver ----------------
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge rclk) begin
        #1;
        case (rdy_mode)
            1: begin
                out_ready = (rdy_ph == 0 || rdy_ph == 3);
                rdy_ph    = (rdy_ph + 1) % 4;
                hold      = 1'b0;
            end
            2: begin
                out_ready = 1'($urandom_range(0, 1));
                hold      = ($urandom_range(0, 5) == 0);
            end
            default: begin
                out_ready = 1'b1;
                hold      = 1'b0;
            end
        endcase
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    longint cyc = 0;
    always @(posedge rclk) cyc++;

    int     occ_m = 0, infl_m = 0;
    int     pops = 0, strobes = 0;
    int     stb_run = 0, max_stb_run = 0, pop_run = 0, max_pop_run = 0;
    longint last_pop_cyc = 0;

    always @(negedge rclk) begin
        int   pop_m, push_m;
        exp_t x;
        if (!reset_n) begin
            occ_m = 0; infl_m = 0;
            stb_run = 0; max_stb_run = 0; pop_run = 0; max_pop_run = 0;
        end else begin
            pop_m  = (out_valid && out_ready) ? 1 : 0;
            push_m = data_gate_out ? 1 : 0;
            check("out_valid_vs_occ", 32'(out_valid), 32'(occ_m != 0));
            if (stb_r) begin
                check("credit_rule", 32'((occ_m + infl_m - pop_m) < 2), 1);
                check("stb_needs_bank", 32'(r_bank_available), 1);
                strobes++;
                stb_run++;
            end else begin
                stb_run = 0;
            end
            if (stb_run > max_stb_run) max_stb_run = stb_run;
            if (push_m == 1) check("push_room", 32'((occ_m - pop_m) < 2), 1);
            if (pop_m == 1) begin
                check("scoreboard_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    check("word_data_sof_eof", 32'({out_data, out_sof, out_eof}), 32'({x.d, x.s, x.e}));
                end
                pops++;
                pop_run++;
                last_pop_cyc = cyc;
            end else begin
                pop_run = 0;
            end
            if (pop_run > max_pop_run) max_pop_run = pop_run;
            occ_m  = occ_m + push_m - pop_m;
            infl_m = stb_r ? 1 : 0;
        end
    end

    // ---------------- stimulus ----------------
    longint done_cyc = 0;

    task automatic push_frame(input int bank, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{d: 16'((bank % 2) * 256 + i), s: (i == 0), e: (i == FLEN - 1)});
        end
    endtask

    task automatic do_reset();
        @(posedge rclk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge rclk); #1;
            if (frame_count == 16'(target) && !busy) begin
                done     = 1'b1;
                done_cyc = cyc;
            end
        end
        check({name, "_completed"}, 32'(done), 1);
        check({name, "_frame_count"}, 32'(frame_count), 32'(target));
        check({name, "_scoreboard_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int b, n, s0, p0;
        reset_n = 1'b0; enable = 1'b0; oneshot = 1'b0; restart = 1'b0;
        #1;
        check("rst_stb_r", 32'(stb_r), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge rclk);
        #1 reset_n = 1'b1;
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_rewind", 32'(rewind), 0);
        enable = 1'b1;

        // oneshot: two banks ready, only one frame until enable toggles
        oneshot = 1'b1;
        b = banks_used;
        push_frame(b, FLEN);
        banks_added = b + 2;
        wait_frames("oneshot_first", 1, 300);
        s0 = strobes;
        repeat (20) @(negedge rclk);
        #1;
        check("oneshot_no_more_strobes", 32'(strobes - s0), 0);
        check("oneshot_idle_busy", 32'(busy), 0);
        check("oneshot_bank_still_ready", 32'(r_bank_available), 1);
        push_frame(b + 1, FLEN);
        @(posedge rclk); #1 enable = 1'b0;
        @(posedge rclk); #1 enable = 1'b1;
        wait_frames("oneshot_second", 2, 300);
        oneshot = 1'b0;

        // basic frame at full throughput
        do_reset();
        b = banks_used;
        push_frame(b, FLEN);
        banks_added = b + 1;
        wait_frames("basic", 1, 300);
        check("basic_consecutive_strobes", 32'(max_stb_run), FLEN);
        check("basic_consecutive_pops", 32'(max_pop_run), FLEN);
        check("basic_busy_falls_after_last_pop", 32'(done_cyc - last_pop_cyc), 1);

        // backpressure 1,0,0,1 over two frames
        do_reset();
        rdy_mode = 1;
        b = banks_used;
        push_frame(b, FLEN);
        push_frame(b + 1, FLEN);
        banks_added = b + 2;
        wait_frames("backpressure", 2, 600);
        rdy_mode = 0;

        // restart after the 4th strobe
        do_reset();
        b = banks_used;
        push_frame(b, 4);
        push_frame(b, FLEN);
        banks_added = b + 1;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge rclk);
            if (stb_r) n++;
        end
        check("restart_saw_4_strobes", 32'(n), 4);
        @(posedge rclk); #1 restart = 1'b1;
        @(negedge rclk);
        check("restart_suppresses_stb", 32'(stb_r), 0);
        @(posedge rclk); #1 restart = 1'b0;
        @(negedge rclk);
        check("rewind_pulse", 32'(rewind), 1);
        check("rewind_no_stb", 32'(stb_r), 0);
        @(negedge rclk);
        check("rewind_one_cycle", 32'(rewind), 0);
        wait_frames("restart", 1, 300);
        check("restart_no_addr_err", 32'(addr_err), 0);

        // async reset in the middle of a frame
        do_reset();
        b = banks_used;
        push_frame(b, FLEN);
        banks_added = b + 1;
        p0 = pops;
        for (int i = 0; i < 200 && (pops - p0) < 5; i++) begin
            @(negedge rclk); #1;
        end
        check("midreset_saw_5_words", 32'(pops - p0 >= 5), 1);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_outputs_zero",
              32'({stb_r, rewind, out_valid, out_sof, out_eof, busy, addr_err}), 0);
        check("midreset_out_data", 32'(out_data), 0);
        check("midreset_frame_count", 32'(frame_count), 0);
        exp_q.delete();
        @(posedge rclk); @(posedge rclk);
        #1 reset_n = 1'b1;
        push_frame(b, FLEN);
        wait_frames("midreset_refill", 1, 300);

        // read address stuck at 2
        do_reset();
        stuck = 1'b1;
        b = banks_used;
        push_frame(b, FLEN);
        banks_added = b + 1;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge rclk);
            if (stb_r) n++;
        end
        check("addr_err_clear_through_idx3_strobe", 32'(addr_err), 0);
        @(negedge rclk);
        check("addr_err_set_after_idx3", 32'(addr_err), 1);
        wait_frames("addr_check", 1, 300);
        check("addr_err_sticky", 32'(addr_err), 1);
        stuck = 1'b0;
        do_reset();
        check("addr_err_cleared_by_reset", 32'(addr_err), 0);

        // randomized ready and bank drops over three frames
        rdy_mode = 2;
        b = banks_used;
        push_frame(b, FLEN);
        push_frame(b + 1, FLEN);
        push_frame(b + 2, FLEN);
        banks_added = b + 3;
        wait_frames("random", 3, 3000);
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
